// File: rtl/win_overlay_reader.sv
// Win-image overlay reader: maps the scan position into a centred 256x256 ROM
// window, realigns ROM data over a fixed 3-cycle pipeline and runs a top-down reveal.
module win_overlay_reader #(
   parameter int          X0        = 192,
   parameter int          Y0        = 112,
   parameter int          WIPE_STEP = 8,
   parameter logic [11:0] KEY_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        show,
   input  logic        frame_start,
   input  logic        video_on,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   output logic [15:0] rom_addr,
   input  logic [11:0] rom_rgb,
   output logic [11:0] pix_rgb,
   output logic        pix_valid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, WIPE, SHOW} state_t;

   localparam logic [9:0] X0_L   = 10'(X0);
   localparam logic [9:0] Y0_L   = 10'(Y0);
   localparam logic [9:0] STEP_L = 10'(WIPE_STEP);

   state_t      state, state_n;
   logic [8:0]  reveal, reveal_n;
   logic [9:0]  rev_sum;
   logic [9:0]  dxw, dyw;
   logic [7:0]  dx, dy;
   logic        in_win, hit, pix_ok;
   logic [2:1]  vld_pipe;

   assign dxw = pix_x - X0_L;
   assign dyw = pix_y - Y0_L;
   assign dx  = dxw[7:0];
   assign dy  = dyw[7:0];

   // 11-bit compares keep the upper bound from wrapping for any window origin
   assign in_win = video_on &&
                   ({1'b0, pix_x} >= {1'b0, X0_L}) && ({1'b0, pix_x} <= {1'b0, X0_L} + 11'd255) &&
                   ({1'b0, pix_y} >= {1'b0, Y0_L}) && ({1'b0, pix_y} <= {1'b0, Y0_L} + 11'd255);

   assign hit    = in_win && (state != IDLE) && ((state == SHOW) || ({1'b0, dy} < reveal));
   assign pix_ok = vld_pipe[2] && (rom_rgb != KEY_COLOR);

   assign rev_sum = {1'b0, reveal} + STEP_L;

   always_comb begin
      state_n  = state;
      reveal_n = reveal;
      case (state)
         IDLE: begin
            reveal_n = 9'd0;
            if (show) state_n = WIPE;
         end
         WIPE: begin
            // dropping show wins over a coincident frame_start
            if (!show) begin
               state_n  = IDLE;
               reveal_n = 9'd0;
            end else if (frame_start) begin
               reveal_n = (rev_sum >= 10'd256) ? 9'd256 : rev_sum[8:0];
               if (reveal_n == 9'd256) state_n = SHOW;
            end
         end
         SHOW: begin
            reveal_n = 9'd256;
            if (!show) begin
               state_n  = IDLE;
               reveal_n = 9'd0;
            end
         end
         default: begin
            state_n  = IDLE;
            reveal_n = 9'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         reveal    <= 9'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rom_addr  <= 16'h0000;
         vld_pipe  <= '0;
         pix_valid <= 1'b0;
         pix_rgb   <= 12'h000;
      end else begin
         state     <= state_n;
         reveal    <= reveal_n;
         busy      <= (state_n == WIPE);
         done      <= (state_n == SHOW);
         rom_addr  <= hit ? {dy, dx} : 16'h0000;
         vld_pipe  <= {vld_pipe[1], hit};
         pix_valid <= pix_ok;
         pix_rgb   <= pix_ok ? rom_rgb : 12'h000;
      end
   end

endmodule

// File: doc/win_overlay_reader.md
Name: win_overlay_reader

Overview:
Read-side client of the 256x256 RGB444 win-image ROM (16-bit address, 12-bit data, one registered read cycle). Takes the VGA scan position, produces ROM addresses for the pixels inside a centred 256x256 window, and realigns the returned data with a valid flag. The win image is revealed top-down, row-wise, over several frames. Output feeds the final VGA colour mux, which delays hsync/vsync by 3 cycles to match.

Parameters:
X0, 192, left column of image window on screen
Y0, 112, top row of image window on screen
WIPE_STEP, 8, image rows revealed per frame during wipe (1..256)
KEY_COLOR, 12'h000, ROM colour treated as transparent (pix_valid forced 0)

Ports:
clk  in  1  pixel clock, same clock as the image ROM
rst  in  1  synchronous, active-high reset
show  in  1  level from game FSM; high while win screen requested
frame_start  in  1  one-cycle pulse at start of each frame (pix_x=0, pix_y=0)
video_on  in  1  scan position is in the visible area
pix_x  in  10  current scan column
pix_y  in  10  current scan row
rom_addr  out  16  address to image ROM, registered
rom_rgb  in  12  ROM data; valid one cycle after rom_addr
pix_rgb  out  12  overlay colour, registered; 0 when pix_valid=0
pix_valid  out  1  overlay pixel present, registered
busy  out  1  high in WIPE state
done  out  1  high in SHOW state

Behaviour:
- Reset: state=IDLE, reveal=0, rom_addr=0, pix_rgb=0, pix_valid=0, busy=0, done=0, internal pipeline valid bits=0.
- dx=pix_x-X0, dy=pix_y-Y0, each truncated to 8 bits. in_win = video_on & pix_x in [X0, X0+255] & pix_y in [Y0, Y0+255].
- hit (stage 0, combinational) = in_win & state!=IDLE & (state==SHOW | dy < reveal). reveal is 9 bits, 0..256, compared unsigned.
- Pipeline, fixed latency 3:
  - cycle t: sample inputs and compute hit.
  - t+1: rom_addr <= hit ? {dy,dx} : 16'h0000, and v1 <= hit.
  - t+2: rom_rgb is valid, and v2 <= v1.
  - t+3: pix_valid <= v2 & (rom_rgb != KEY_COLOR), and pix_rgb <= that pixel's valid ? rom_rgb : 0.
- Pipeline runs every cycle with no stall and is independent of state changes. In-flight entries complete even if show drops; only rst clears v1/v2.
- FSM:
  - IDLE: reveal=0. On show=1, next state is WIPE.
  - WIPE: on each frame_start, reveal <= min(reveal+WIPE_STEP, 256). When the updated value is 256, next state is SHOW in the same edge. reveal changes only at frame_start, so a frame never shows a partially updated edge.
  - SHOW: reveal held at 256 and the whole image is visible.
  - show=0 in WIPE or SHOW: next state is IDLE and reveal <= 0. This has priority over a simultaneous frame_start.
  - show=1 together with frame_start in IDLE: enter WIPE with reveal=0; the first increment happens at the next frame_start.
- busy = (state==WIPE) and done = (state==SHOW), both registered with the state.
- Window boundaries: pix_x=X0-1 and X0+256 give no hit; pix_x=X0+255, pix_y=Y0+255 gives addr 16'hFFFF.
- Reset mid-wipe returns to IDLE with reveal=0 and clears outputs on the next edge.

Test Plan:
- Reset, then show=1, then 32 frame_start pulses with WIPE_STEP=8 -> busy=1 after the first edge; reveal reaches 256 at pulse 32; done=1 and busy=0 from that edge.
- SHOW state, scan pix_x=192, pix_y=112 at cycle t -> rom_addr=16'h0000 at t+1; ROM model returns 12'hF80 -> pix_rgb=12'hF80, pix_valid=1 at t+3.
- SHOW state, pix_x=447, pix_y=367 -> rom_addr=16'hFFFF. Pixels at pix_x=191, pix_x=448, pix_y=368 and video_on=0 -> pix_valid=0, pix_rgb=0, rom_addr=0.
- WIPE with reveal=16: pixel at dy=15 -> pix_valid=1; pixel at dy=16 -> pix_valid=0.
- SHOW state, ROM returns KEY_COLOR 12'h000 for an in-window pixel -> pix_valid=0, pix_rgb=0. The adjacent pixel with 12'h0F0 -> pix_valid=1.
- show dropped in the same cycle as frame_start during WIPE -> IDLE and reveal=0 next edge; the two in-flight pixels still appear at t+3. Repeat with rst=1 mid-wipe -> all outputs 0 next edge.
